// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcode/funct constants and ALU codes for the multi-cycle control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

endpackage

// File: rtl/alu_ctl_dec.sv
// R-type funct decoder: maps funct to an ALU code; valid_o low for unsupported functs.
module alu_ctl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    valid_o   = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctl_o = ALU_ADD;
      FN_SUB:  alu_ctl_o = ALU_SUB;
      FN_AND:  alu_ctl_o = ALU_AND;
      FN_OR:   alu_ctl_o = ALU_OR;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite main control FSM; all datapath controls decode combinationally from state.
// Define MC_CTRL_MEM_WAIT_EN to add mem_ready, which stalls FETCH/MEM_RD/MEM_WR until memory responds.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int         ALU_CTL_W   = 4,
  parameter logic [3:0] RESET_STATE = 4'd0
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 halted,
  output logic [3:0]           state
);

  state_e     state_q, state_d;
  logic       mem_rdy;
  logic [3:0] alu_code;
  logic [3:0] fn_alu;
  logic       fn_valid;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  alu_ctl_dec u_alu_ctl_dec (
    .funct_i   (funct),
    .alu_ctl_o (fn_alu),
    .valid_o   (fn_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= state_e'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_code   = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC/IR load only in the cycle memory delivers, so a stall updates them once
        mem_read  = 1'b1;
        ir_write  = mem_rdy;
        pc_en     = mem_rdy;
        alu_src_b = 2'd1;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:       state_d = fn_valid ? S_EXEC : S_TRAP;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_code  = fn_alu;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'd1;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'd2;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_ORI) begin
          alu_code = ALU_OR;
          ext_zero = 1'b1;
        end
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: halted = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign alu_ctl = ALU_CTL_W'(alu_code);
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction expected control trace.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;

  logic [3:0] alu_ctl;
  logic       alu_src_a, ext_zero, pc_en, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .alu_ctl    (alu_ctl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       ez;
    logic       pe;
    logic [1:0] ps;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       hlt;
  } ctl_t;

  wire [22:0] obs = {state, alu_ctl, alu_src_a, alu_src_b, ext_zero, pc_en, pc_src, i_or_d,
                     mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, halted};

  int   n_checks = 0;
  int   n_pass   = 0;
  ctl_t q[$];
  logic rq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.hlt = (st == 4'd15);
    return c;
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t c;
    c = blank(4'd0);
    c.mr = 1'b1; c.irw = 1'b1; c.sb = 2'd1; c.pe = 1'b1;
    return c;
  endfunction

  function automatic int waits();
`ifdef MC_CTRL_MEM_WAIT_EN
    return int'($urandom_range(0, 2));
`else
    return 0;
`endif
  endfunction

  task automatic push(input ctl_t c, input logic rdy);
    q.push_back(c);
    rq.push_back(rdy);
  endtask

  // A memory state stalls w cycles before the ready cycle; a stalled fetch must not load PC/IR.
  task automatic push_mem(input ctl_t c, input int w);
    ctl_t s;
    s = c;
    s.pe = 1'b0;
    s.irw = 1'b0;
    for (int i = 0; i < w; i++) push((c.st == 4'd0) ? s : c, 1'b0);
    push(c, 1'b1);
  endtask

  // Expected trace of one instruction, FETCH through its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int w, output bit trapped);
    ctl_t c;
    logic [3:0] fa;
    trapped = 1'b0;
    case (fn)
      6'h20: fa = 4'd0;
      6'h22: fa = 4'd1;
      6'h24: fa = 4'd2;
      6'h25: fa = 4'd3;
      default: fa = 4'hF;
    endcase
    push_mem(fetch_ctl(), w);
    c = blank(4'd1); c.sb = 2'd3; push(c, 1'b1);
    if (op == 6'h00 && fa != 4'hF) begin
      c = blank(4'd6); c.sa = 1'b1; c.alu = fa; push(c, 1'b1);
      c = blank(4'd7); c.rw = 1'b1; c.rd = 1'b1; push(c, 1'b1);
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = blank(4'd2); c.sa = 1'b1; c.sb = 2'd2; push(c, 1'b1);
      if (op == 6'h23) begin
        c = blank(4'd3); c.mr = 1'b1; c.iod = 1'b1; push_mem(c, w);
        c = blank(4'd4); c.rw = 1'b1; c.m2r = 1'b1; push(c, 1'b1);
      end else begin
        c = blank(4'd5); c.mw = 1'b1; c.iod = 1'b1; push_mem(c, w);
      end
    end else if (op == 6'h04) begin
      c = blank(4'd8); c.sa = 1'b1; c.alu = 4'd1; c.ps = 2'd1; c.pe = z; push(c, 1'b1);
    end else if (op == 6'h02) begin
      c = blank(4'd9); c.ps = 2'd2; c.pe = 1'b1; push(c, 1'b1);
    end else if (op == 6'h08 || op == 6'h0D) begin
      c = blank(4'd10); c.sa = 1'b1; c.sb = 2'd2;
      if (op == 6'h0D) begin c.alu = 4'd3; c.ez = 1'b1; end
      push(c, 1'b1);
      c = blank(4'd11); c.rw = 1'b1; push(c, 1'b1);
    end else begin
      trapped = 1'b1;
      for (int i = 0; i < 20; i++) push(blank(4'd15), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic run(input string tag, input int n);
    ctl_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      mem_ready = rq.pop_front();
      @(negedge clk);
      chk($sformatf("%s_c%0d_st%0d", tag, i, e.st), 32'(obs), 32'(e));
      @(posedge clk); #1;
    end
    q.delete();
    rq.delete();
  endtask

  // Reset asserted between edges must reach FETCH without a clock.
  task automatic do_reset(input string tag);
    #2;
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk({tag, "_async_rst"}, 32'(obs), 32'(fetch_ctl()));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int w);
    bit tr;
    opcode = op; funct = fn; zero = z;
    build(op, fn, z, w, tr);
    run(tag, 1000);
    if (tr) do_reset(tag);
  endtask

  logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h24, 6'h25};
  logic [5:0] ops[7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0D};

  initial begin
    bit tr;
    #3;
    chk("reset_state", 32'(obs), 32'(fetch_ctl()));
    @(posedge clk); #1;
    rst = 1'b0;

    instr("lw",      6'h23, 6'h00, 1'b0, 0);
    instr("sub",     6'h00, 6'h22, 1'b0, 0);
    instr("beq_t",   6'h04, 6'h00, 1'b1, 0);
    instr("beq_nt",  6'h04, 6'h00, 1'b0, 0);
    instr("ori",     6'h0D, 6'h00, 1'b0, 0);
    instr("addi",    6'h08, 6'h00, 1'b0, 0);
    instr("j",       6'h02, 6'h00, 1'b0, 0);
    instr("sw",      6'h2B, 6'h00, 1'b0, 0);
    instr("bad_op",  6'h3F, 6'h20, 1'b0, 0);
    instr("bad_fn",  6'h00, 6'h27, 1'b0, 0);

    // Reset in the middle of a load abandons it.
    opcode = 6'h23; funct = 6'h00;
    build(6'h23, 6'h00, 1'b0, 0, tr);
    run("lw_abort", 3);
    do_reset("lw_abort");
    instr("after_abort", 6'h00, 6'h20, 1'b0, 0);

`ifdef MC_CTRL_MEM_WAIT_EN
    instr("sw_wait3", 6'h2B, 6'h00, 1'b0, 3);
    instr("lw_wait2", 6'h23, 6'h00, 1'b0, 2);
    opcode = 6'h2B;
    build(6'h2B, 6'h00, 1'b0, 3, tr);
    run("sw_wait_abort", 4);
    do_reset("sw_wait_abort");
    instr("after_wait_abort", 6'h02, 6'h00, 1'b0, 0);
`endif

    for (int k = 0; k < 250; k++) begin
      int sel;
      logic [5:0] op, fn;
      sel = int'($urandom_range(0, 31));
      if (sel == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else if (sel == 1) begin
        op = 6'h00; fn = 6'($urandom);
      end else begin
        op = ops[sel % 7];
        fn = fns[$urandom_range(0, 3)];
      end
      instr($sformatf("rnd%0d", k), op, fn, 1'($urandom), waits());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS-lite datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux, enable and the 4-bit ALU control code, so it is the producer side of the ALU ctl interface.
- Sits beside the datapath and reads opcode/funct from the instruction register and zero from the ALU.

Parameters:
- ALU_CTL_W, 4, width of alu_ctl.
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- alu_ctl  output  4  0=add, 1=sub, 2=and, 3=or.
- alu_src_a  output  1  0=PC, 1=regA.
- alu_src_b  output  2  0=regB, 1=const 4, 2=ext imm, 3=ext imm<<2.
- ext_zero  output  1  1=zero-extend imm, 0=sign-extend.
- pc_en  output  1  PC write enable.
- pc_src  output  2  0=ALU result, 1=ALUOut, 2=jump target.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  0=rt, 1=rd.
- mem_to_reg  output  1  0=ALUOut, 1=MDR.
- reg_write  output  1  register file write enable.
- halted  output  1  FSM is in TRAP.
- state  output  4  current state, for debug.

Behaviour:
- Reset and encoding:
  - clk and rst are the only clock and reset; rst is asynchronous, active-high.
  - rst forces state=FETCH at any time, including mid-instruction.
  - The interrupted instruction is abandoned: no further writes, and the PC is not advanced for it.
  - State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, TRAP=15.
- Output rules:
  - All outputs decode combinationally from state, plus opcode/funct and zero where noted.
  - Any output not listed for a state is 0, except alu_ctl, which defaults to 0 (add).
- Per-state outputs and transitions:
  - FETCH: mem_read, ir_write, alu_src_b=1, add, pc_en=1, pc_src=0 -> DECODE.
  - DECODE: alu_src_b=3, add (branch target precompute).
  - DECODE transitions by opcode:
    - 0x00 with funct in {0x20, 0x22, 0x24, 0x25} -> EXEC.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x08 or 0x0D -> IMM_EXEC.
    - Anything else, including an unlisted funct -> TRAP.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, add -> MEM_RD if lw, MEM_WR if sw.
  - MEM_RD: mem_read, i_or_d=1 -> MEM_WB.
  - MEM_WB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WR: mem_write, i_or_d=1 -> FETCH.
  - EXEC: alu_src_a=1, alu_src_b=0, alu_ctl from funct (0x20->0, 0x22->1, 0x24->2, 0x25->3) -> ALU_WB.
  - ALU_WB: reg_write, reg_dst=1 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_en=zero -> FETCH.
  - JUMP: pc_src=2, pc_en=1 -> FETCH.
  - IMM_EXEC: alu_src_a=1, alu_src_b=2.
    - opcode 0x08: add, ext_zero=0.
    - opcode 0x0D: or, ext_zero=1.
    - -> IMM_WB.
  - IMM_WB: reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
  - TRAP: halted=1, all enables 0; stays in TRAP until rst.
- Latency in cycles from FETCH: lw 5; sw, R-type, addi, ori 4; beq, j 3.
- mem_read and mem_write are never high in the same cycle. reg_write and ir_write are never high in the same cycle.

Optional Feature:
- Macro: MC_CTRL_MEM_WAIT_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEM_RD and MEM_WR hold, with outputs unchanged, while mem_ready=0.
  - pc_en and ir_write in FETCH are gated by mem_ready, so PC/IR update exactly once.
  - The state transition happens in the cycle mem_ready=1.
  - rst during a wait still returns to FETCH.
- When undefined: the port is absent and memory is treated as single-cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI;
  - funct constants;
  - ALU codes ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3.
- One sub-module, alu_ctl_dec: combinational funct -> {alu_ctl, valid}. DECODE uses valid to choose EXEC or TRAP; EXEC uses alu_ctl.

Test Plan:
- rst=1 then release; opcode=0x23 held -> state sequence 0,1,2,3,4,0; mem_read in cycles 1 and 4; reg_write with mem_to_reg=1 only in cycle 5.
- R-type with funct=0x22 -> EXEC drives alu_ctl=1, alu_src_a=1, alu_src_b=0; ALU_WB has reg_write=1, reg_dst=1; total 4 cycles.
- beq with zero=1 -> in BRANCH, pc_en=1, pc_src=1, alu_ctl=1. Repeat with zero=0 -> pc_en=0; back to FETCH either way.
- ori (0x0D) -> IMM_EXEC drives alu_ctl=3, ext_zero=1. addi (0x08) -> alu_ctl=0, ext_zero=0; reg_write in IMM_WB.
- opcode=0x3F, and separately R-type funct=0x27 -> state=15 and halted=1, held 20 cycles; assert rst -> state=0 on the same edge, no clock needed.
- With MC_CTRL_MEM_WAIT_EN: sw with mem_ready=0 for 3 cycles in MEM_WR -> mem_write held 4 cycles, one transition to FETCH. rst pulse mid-wait -> FETCH, no mem_write afterwards.
